// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing on a synchronized rx line.
// Emits a one-clk data_valid on a good stop bit, or a one-clk frame_error on a low one.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   data_valid_q, valid_d;
    logic                   frame_error_q, ferr_d;
    logic                   busy_q, busy_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (baud_tick) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s_q) state_d = START;
            START:     if (tick_cnt_q == TICK_HALF) state_d = rx_s_q ? IDLE : DATA;
            DATA:      if (tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
            STOP:      if (tick_cnt_q == TICK_LAST) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counters, shifter and result strobes for the current tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
            end
            START: begin
                if (tick_cnt_q == TICK_HALF) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            DATA: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                end
            end
            STOP: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (rx_s_q) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                tick_cnt_d = '0;
            end
            default: begin
                tick_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Strobes self-clear on the next clk; everything else only moves on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            data_valid_q  <= baud_tick & valid_d;
            frame_error_q <= baud_tick & ferr_d;
            if (baud_tick) begin
                tick_cnt_q <= tick_cnt_d;
                bit_cnt_q  <= bit_cnt_d;
                shift_q    <= shift_d;
                data_out_q <= data_out_d;
                busy_q     <= busy_d;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner sequences, a frame table,
// and random frames judged by a frame-level outcome model.
module tb_uart_rx;

    localparam int unsigned DB       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = OS * TICK_DIV;

    logic       clk, reset, baud_tick, rx;
    logic [7:0] data_out;
    logic       data_valid, frame_error, busy;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    int nvalid, nferr, nbusy, viol;
    logic prev_v, prev_f;
    logic [7:0] prev_dout;
    logic tick_en;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;
        int         ev;
        int         ef;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every TICK_DIV clks; gating also freezes the phase.
    initial begin
        int cnt;
        cnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                baud_tick = (cnt == TICK_DIV - 1);
                cnt = (cnt + 1) % TICK_DIV;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    // Pulse/event monitor: counts strobes and flags protocol violations.
    initial begin
        nvalid = 0; nferr = 0; nbusy = 0; viol = 0;
        prev_v = 1'b0; prev_f = 1'b0; prev_dout = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (data_valid === 1'b1) begin
                    nvalid++;
                    if (prev_v) viol++;
                end
                if (frame_error === 1'b1) begin
                    nferr++;
                    if (prev_f) viol++;
                    if (data_valid === 1'b1) viol++;
                end
                if (data_out !== prev_dout && data_valid !== 1'b1) viol++;
                if (busy === 1'b1) nbusy++;
            end
            prev_v    = (data_valid === 1'b1);
            prev_f    = (frame_error === 1'b1);
            prev_dout = data_out;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic wait_idle(input int max_clks);
        for (int i = 0; i < max_clks && busy !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop, input int idle,
                             input int ev, input int ef, input logic [7:0] edout,
                             input string name);
        int bv, bf;
        bv = nvalid;
        bf = nferr;
        send_bits(d, stop);
        check({name, "_valid_cnt"}, 32'(nvalid - bv), 32'(ev));
        check({name, "_ferr_cnt"}, 32'(nferr - bf), 32'(ef));
        check({name, "_data_out"}, 32'(data_out), 32'(edout));
        if (idle > 0) begin
            rx = 1'b1;
            repeat (idle * BIT_CLKS) @(negedge clk);
            check({name, "_busy_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int bv, bf, bb, idle;
        logic [7:0] d, hold, exp_last;
        logic stop;

        tbl[0] = '{8'h81, 1'b1, 1, 1, 0, 8'h81};
        tbl[1] = '{8'h3C, 1'b0, 1, 0, 1, 8'h81};
        tbl[2] = '{8'h55, 1'b1, 0, 1, 0, 8'h55};
        tbl[3] = '{8'hAA, 1'b1, 0, 1, 0, 8'hAA};
        tbl[4] = '{8'h01, 1'b1, 1, 1, 0, 8'h01};
        tbl[5] = '{8'h80, 1'b0, 2, 0, 1, 8'h01};
        tbl[6] = '{8'hFE, 1'b1, 1, 1, 0, 8'hFE};

        tick_en = 1'b1;
        rx      = 1'b1;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_ferr", 32'(frame_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        run_frame(8'hA5, 1'b1, 1, 1, 0, 8'hA5, "frame_a5");

        // Short low glitch must be rejected at the start-bit midpoint.
        bv = nvalid; bf = nferr; bb = nbusy;
        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_busy_seen", 32'(nbusy > bb), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_valid_cnt", 32'(nvalid - bv), 32'd0);
        check("glitch_ferr_cnt", 32'(nferr - bf), 32'd0);

        // Bad stop bit followed by a held-low break.
        bv = nvalid; bf = nferr;
        send_bits(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40 * TICK_DIV) @(negedge clk);
        check("break_ferr_cnt", 32'(nferr - bf), 32'd1);
        check("break_valid_cnt", 32'(nvalid - bv), 32'd0);
        check("break_data_out", 32'(data_out), 32'hA5);
        check("break_busy_low", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_idle(4 * BIT_CLKS);
        check("break_busy_release", 32'(busy), 32'd0);
        check("break_ferr_total", 32'(nferr - bf), 32'd1);
        repeat (BIT_CLKS) @(negedge clk);

        run_frame(8'h00, 1'b1, 0, 1, 0, 8'h00, "b2b_00");
        run_frame(8'hFF, 1'b1, 1, 1, 0, 8'hFF, "b2b_ff");

        // Reset in the middle of a data bit aborts the frame silently.
        bv = nvalid; bf = nferr;
        d = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("abort_valid_cnt", 32'(nvalid - bv), 32'd0);
        check("abort_ferr_cnt", 32'(nferr - bf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        run_frame(8'h5A, 1'b1, 1, 1, 0, 8'h5A, "after_abort");

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].data, tbl[i].stop, tbl[i].idle, tbl[i].ev, tbl[i].ef,
                      tbl[i].dout, $sformatf("tbl%0d", i));

        // Ticks gated off mid-bit must freeze the receiver.
        bv = nvalid;
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        tick_en = 1'b0;
        hold = data_out;
        repeat (200) @(negedge clk);
        check("freeze_busy", 32'(busy), 32'd1);
        check("freeze_valid_cnt", 32'(nvalid - bv), 32'd0);
        check("freeze_data_out", 32'(data_out), 32'(hold));
        tick_en = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 4; i < DB; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        check("freeze_resume_valid", 32'(nvalid - bv), 32'd1);
        check("freeze_resume_data", 32'(data_out), 32'hC3);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Random frames: good stop publishes the word, bad stop keeps the last good one.
        exp_last = 8'hC3;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            idle = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            if (stop) exp_last = d;
            run_frame(d, stop, idle, stop ? 1 : 0, stop ? 0 : 1, exp_last,
                      $sformatf("rand%0d", n));
        end
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("pulse_protocol_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame (legal range 5-9).
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set the number of baud_tick pulses per bit period; it SHALL be a power of two, at least 8.
REQ-003 clk  input  1  SHALL be the single system clock; all logic samples on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 baud_tick  input  1  SHALL be a one-clk-wide pulse at OVERSAMPLE x baud rate, from the baud generator.
REQ-006 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-007 data_out  output  DATA_BITS  SHALL carry the last correctly framed received word.
REQ-008 data_valid  output  1  SHALL pulse for one clk when data_out is updated.
REQ-009 frame_error  output  1  SHALL pulse for one clk when a stop bit is sampled low.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer, reset value 1; all FSM decisions SHALL use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 State, counter and shift-register updates SHALL occur only on clk edges where baud_tick=1; data_valid and frame_error SHALL still clear on the next clk.
REQ-014 Tick counter width SHALL be log2(OVERSAMPLE) bits; bit counter width SHALL be ceil(log2(DATA_BITS+1)) bits.
REQ-015 IDLE: on tick with rx_s=0 -> START, tick_cnt=0.
REQ-016 START: tick_cnt increments each tick; at tick_cnt=OVERSAMPLE/2-1, rx_s=0 -> DATA with tick_cnt=0, bit_cnt=0; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: at tick_cnt=OVERSAMPLE-1, rx_s SHALL shift in LSB-first, tick_cnt wraps to 0, bit_cnt increments; after the DATA_BITS-th sample -> STOP.
REQ-018 STOP: at tick_cnt=OVERSAMPLE-1, rx_s=1 -> data_out<=shift register, data_valid=1, next state IDLE.
REQ-019 STOP: at tick_cnt=OVERSAMPLE-1, rx_s=0 -> frame_error=1, data_out unchanged, data_valid=0, next state WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until a tick with rx_s=1, then -> IDLE; a held-low line (break) SHALL yield exactly one frame_error.
REQ-021 data_valid and frame_error SHALL never be high in the same cycle and SHALL each be exactly one clk wide.
REQ-022 A new start bit SHALL be accepted on the first tick after returning to IDLE, supporting back-to-back frames with one stop bit.
REQ-023 baud_tick held low SHALL freeze all state with no output change.

Reset
REQ-024 With reset=1 at a clk edge: state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, data_out=0, data_valid=0, frame_error=0, busy=0, synchronizer flops=1.
REQ-025 reset SHALL take priority over baud_tick and abort any frame in progress without any output pulse.

Verification (DATA_BITS=8, OVERSAMPLE=16, baud_tick every 4 clk)
REQ-026 Reset: assert reset 2 clk, rx=1 -> all outputs 0, busy=0.
REQ-027 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> data_out=0xA5, data_valid high exactly 1 clk, frame_error=0, busy=0 afterwards.
REQ-028 rx low for 4 ticks then high -> busy pulses, returns to IDLE, no data_valid, no frame_error.
REQ-029 Frame 0x3C with stop=0, then rx low 40 more ticks -> single frame_error pulse, data_out stays 0xA5, busy=1 until rx returns high.
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses with data_out 0x00 then 0xFF.
REQ-031 reset asserted mid-DATA of 0x77, then frame 0x5A -> no pulse for 0x77; data_out=0x5A with one data_valid.
